crbar2_sort_sched: RTL and testbench

Scheduler that time-multiplexes one crbar2 2x2 crossbar as a compare-and-swap element, running a 4-element odd-even transposition sort on signed fixed-point activations.

---
 rtl/crbar2_sort_sched_pkg.sv | 24 ++
 rtl/crbar2_sort_sched_crbar2.sv | 16 +
 rtl/crbar2_sort_sched.sv | 125 ++++++++++++
 tb/tb_crbar2_sort_sched.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crbar2_sort_sched_pkg.sv
// Shared definitions for the crbar2 sort scheduler: FSM encoding and the
// odd-even transposition pair schedule.
package crbar2_sort_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SORT_STEPS = 6;

  // Pair schedule packed two bits per step, step k at [2k +: 2] (step5 written first).
  // PAIR_I = {0,2,1,0,2,1}, PAIR_J = {1,3,2,1,3,2} for steps 0..5.
  localparam logic [2*SORT_STEPS-1:0] PAIR_I = {2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
  localparam logic [2*SORT_STEPS-1:0] PAIR_J = {2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};

  function automatic logic [1:0] pair_sel(input logic [2*SORT_STEPS-1:0] tbl,
                                          input logic [2:0] step);
    return tbl[{step, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/crbar2_sort_sched_crbar2.sv
// crbar2: 2x2 crossbar switch. s=0 passes x1->y1, x2->y2; s=1 crosses them.
module crbar2 #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         s,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] x2,
  output logic [N-1:0] y1,
  output logic [N-1:0] y2
);

  assign y1 = s ? x2 : x1;
  assign y2 = s ? x1 : x2;

endmodule

// File: rtl/crbar2_sort_sched.sv
// Loads a 4-element pooling window, sorts it with a time-multiplexed crbar2
// compare-swap over a fixed 6-step schedule, and holds the result until taken.
module crbar2_sort_sched
  import crbar2_sort_sched_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  input  logic           dir,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*N-1:0] out_data,
  output logic [N-1:0]   out_max,
  output logic [2:0]     swap_cnt,
  output logic           busy
);

  state_t       state;
  logic [N-1:0] r [4];
  logic [1:0]   cnt;
  logic [2:0]   step;
  logic         dir_q;

  logic         s;
  logic [1:0]   pi;
  logic [1:0]   pj;
  logic [N-1:0] x1;
  logic [N-1:0] x2;
  logic [N-1:0] y1;
  logic [N-1:0] y2;

  assign pi = pair_sel(PAIR_I, step);
  assign pj = pair_sel(PAIR_J, step);
  assign x1 = r[pi];
  assign x2 = r[pj];

  // Swap whenever the pair is strictly out of order; ties stay put so s is 0.
  always_comb begin
    s = 1'b0;
    if (state == SORT) begin
      if (dir_q) s = ($signed(x1) > $signed(x2));
      else       s = ($signed(x1) < $signed(x2));
    end
  end

  crbar2 #(
    .Q(Q),
    .N(N)
  ) u_xbar (
    .s (s),
    .x1(x1),
    .x2(x2),
    .y1(y1),
    .y2(y2)
  );

  assign out_data = {r[3], r[2], r[1], r[0]};
  assign out_max  = dir_q ? r[3] : r[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      r         <= '{default: '0};
      cnt       <= '0;
      step      <= '0;
      dir_q     <= 1'b0;
      swap_cnt  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r[0]  <= in_data;
            dir_q <= dir;
            cnt   <= 2'd1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            r[cnt] <= in_data;
            if (cnt == 2'd3) begin
              state    <= SORT;
              step     <= '0;
              swap_cnt <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        SORT: begin
          r[pi] <= y1;
          r[pj] <= y2;
          if (s) swap_cnt <= swap_cnt + 3'd1;
          if (step == 3'(SORT_STEPS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            step <= step + 3'd1;
          end
        end
        DONE: begin
          // in_ready comes back only after the handoff edge, so no same-cycle reload.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crbar2_sort_sched.sv
// Self-checking bench for crbar2_sort_sched: a scoreboard of expected sorted
// windows is filled as windows are loaded and drained as results appear.
module tb_crbar2_sort_sched;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic           dir;
  logic           out_valid;
  logic           out_ready;
  logic [4*N-1:0] out_data;
  logic [N-1:0]   out_max;
  logic [2:0]     swap_cnt;
  logic           busy;

  typedef struct {
    logic [4*N-1:0] data;
    logic [N-1:0]   mx;
    logic [2:0]     sc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  crbar2_sort_sched #(.Q(15), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .dir      (dir),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_max  (out_max),
    .swap_cnt (swap_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference: full sort by selection, swap count = number of strict inversions.
  function automatic exp_t model(input logic [4*N-1:0] win, input logic d);
    logic signed [N-1:0] a [4];
    logic signed [N-1:0] t;
    logic signed [N-1:0] mx;
    exp_t e;
    int inv;
    inv = 0;
    for (int i = 0; i < 4; i++) a[i] = win[i*N +: N];
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (d ? (a[i] > a[j]) : (a[i] < a[j])) inv++;
    mx = a[0];
    for (int i = 1; i < 4; i++) if (a[i] > mx) mx = a[i];
    for (int i = 0; i < 3; i++)
      for (int j = i + 1; j < 4; j++)
        if (d ? (a[j] < a[i]) : (a[j] > a[i])) begin
          t = a[i]; a[i] = a[j]; a[j] = t;
        end
    for (int i = 0; i < 4; i++) e.data[i*N +: N] = a[i];
    e.mx = mx;
    e.sc = 3'(inv);
    return e;
  endfunction

  task automatic applyStimulus(input logic [4*N-1:0] win, input logic d,
                               input logic [15:0] vpat, input int npat);
    int idx;
    int k;
    logic acc;
    idx = 0;
    k   = 0;
    sb.push_back(model(win, d));
    while (idx < 4 && k < 40) begin
      @(negedge clk);
      in_valid = (k < npat) ? vpat[k] : 1'b1;
      in_data  = in_valid ? win[idx*N +: N] : 32'hDEADBEEF;
      dir      = (idx == 0) ? d : ~d;
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      k++;
    end
    n_checks++;
    if (idx != 4) begin
      n_fail++;
      $display("[TB] FAIL load_words: accepted %0d, required 4", idx);
    end
  endtask

  // Waits for out_valid after the e3 edge and compares against the scoreboard head.
  task automatic checkOutput(input string name, input logic chk_s, output exp_t e);
    int lat;
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 30) begin
      if (chk_s) begin
        n_checks++;
        if (dut.s !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL %s_s_low: s=%b at edge %0d, required 0", name, dut.s, lat);
        end
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s_timeout: out_valid never rose", name);
    end
    n_checks++;
    if (lat != 6) begin
      n_fail++;
      $display("[TB] FAIL %s_latency: got %0d edges, required 6", name, lat);
    end
    n_checks++;
    if (out_data !== e.data) begin
      n_fail++;
      $display("[TB] FAIL %s_data: got %h, required %h", name, out_data, e.data);
    end
    n_checks++;
    if (out_max !== e.mx) begin
      n_fail++;
      $display("[TB] FAIL %s_max: got %h, required %h", name, out_max, e.mx);
    end
    n_checks++;
    if (swap_cnt !== e.sc) begin
      n_fail++;
      $display("[TB] FAIL %s_swaps: got %0d, required %0d", name, swap_cnt, e.sc);
    end
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s_done_flags: busy=%b in_ready=%b, required 1/0", name, busy, in_ready);
    end
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s_handoff: out_valid=%b in_ready=%b busy=%b, required 0/1/0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, required 1/0/0",
               in_ready, out_valid, busy);
    end
    n_checks++;
    if (out_data !== '0 || out_max !== '0 || swap_cnt !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: data=%h max=%h swaps=%0d, required zeros",
               out_data, out_max, swap_cnt);
    end
  endtask

  task automatic test_desc();
    exp_t e;
    applyStimulus({32'hFFFF8000, 32'h00008000, 32'h00020000, 32'h00018000}, 1'b0, 16'hFFFF, 0);
    checkOutput("desc", 1'b0, e);
    n_checks++;
    if (out_data !== {32'hFFFF8000, 32'h00008000, 32'h00018000, 32'h00020000} ||
        out_max !== 32'h00020000 || swap_cnt !== 3'd1) begin
      n_fail++;
      $display("[TB] FAIL desc_known: data=%h max=%h swaps=%0d", out_data, out_max, swap_cnt);
    end
    handshake("desc");
  endtask

  task automatic test_asc();
    exp_t e;
    applyStimulus({32'd1, 32'd2, 32'd3, 32'd4}, 1'b1, 16'hFFFF, 0);
    checkOutput("asc", 1'b0, e);
    n_checks++;
    if (out_data !== {32'd4, 32'd3, 32'd2, 32'd1} || out_max !== 32'd4 || swap_cnt !== 3'd6) begin
      n_fail++;
      $display("[TB] FAIL asc_known: data=%h max=%h swaps=%0d", out_data, out_max, swap_cnt);
    end
    handshake("asc");
  endtask

  task automatic test_equal();
    exp_t e;
    applyStimulus({4{32'h00010000}}, 1'b0, 16'hFFFF, 0);
    checkOutput("equal", 1'b1, e);
    handshake("equal");
  endtask

  task automatic test_backpressure();
    exp_t e;
    applyStimulus({32'h80000000, 32'h7FFFFFFF, 32'h00000005, 32'hFFFFFFFB}, 1'b0, 16'hFFFF, 0);
    checkOutput("bp", 1'b0, e);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = c[0] ? 1'b0 : 1'b1;
      in_data  = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.data ||
          out_max !== e.mx || swap_cnt !== e.sc) begin
        n_fail++;
        $display("[TB] FAIL bp_hold_%0d: valid=%b ready=%b data=%h max=%h sc=%0d, required 1/0/%h/%h/%0d",
                 c, out_valid, in_ready, out_data, out_max, swap_cnt, e.data, e.mx, e.sc);
      end
    end
    in_valid = 1'b0;
    handshake("bp");
  endtask

  task automatic test_gaps();
    exp_t e;
    // in_valid sequence 1,0,0,1,1,0,1 (bit0 first)
    applyStimulus({32'hFFFFFFFE, 32'h00000009, 32'h00000000, 32'h00000003}, 1'b1, 16'b1011001, 7);
    checkOutput("gaps", 1'b0, e);
    handshake("gaps");
  endtask

  task automatic test_reset_mid_sort();
    bit seen;
    exp_t e;
    applyStimulus({32'd7, 32'd1, 32'd9, 32'd3}, 1'b0, 16'hFFFF, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_back());
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_idle: in_ready=%b out_valid=%b busy=%b, required 1/0/0",
               in_ready, out_valid, busy);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("[TB] FAIL midreset_novalid: out_valid=1 seen, required 0");
    end
    applyStimulus({32'd7, 32'd1, 32'd9, 32'd3}, 1'b0, 16'hFFFF, 0);
    checkOutput("midreset_fresh", 1'b0, e);
    handshake("midreset_fresh");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [4*N-1:0] win;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 4; i++)
        win[i*N +: N] = t[0] ? $urandom() : 32'($signed($urandom_range(0, 6)) - 3);
      applyStimulus(win, t[1], 16'hFFFF, 0);
      checkOutput("b2b", 1'b0, e);
      handshake("b2b");
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    dir       = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_desc();
    test_asc();
    test_equal();
    test_backpressure();
    test_gaps();
    test_reset_mid_sort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
